// File: rtl/apbdma_upsizer_flush.sv
// apbdma_upsizer_flush
// Packs Ratio = OutDataWidth/InDataWidth narrow beats into one wide beat, lane 0 first.
// A beat with in_last_i flushes the partially filled word, with unwritten lanes zeroed.
// A separate output register gives full throughput and a one-cycle latency.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   in_data_i/strb_i      narrow beat data and byte strobes
//   in_last_i             final narrow beat of the burst
//   in_valid_i/ready_o    narrow handshake
//   out_data_o/strb_o     packed wide data and strobes
//   out_last_o            wide beat ends the burst
//   out_valid_o/ready_i   wide handshake
//   out_beats_o           narrow beats in the current wide beat
//                         (present only with APBDMA_UPSIZER_BEAT_COUNT_EN)
module apbdma_upsizer_flush #(
  parameter int unsigned InDataWidth  = 32,
  parameter int unsigned OutDataWidth = 128,
  localparam int unsigned Ratio        = OutDataWidth / InDataWidth,
  localparam int unsigned CntWidth     = (Ratio > 2) ? $clog2(Ratio) : 1,
  localparam int unsigned InStrbWidth  = InDataWidth / 8,
  localparam int unsigned OutStrbWidth = OutDataWidth / 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [InDataWidth-1:0]  in_data_i,
  input  logic [InStrbWidth-1:0]  in_strb_i,
  input  logic                    in_last_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [OutDataWidth-1:0] out_data_o,
  output logic [OutStrbWidth-1:0] out_strb_o,
  output logic                    out_last_o,
  output logic                    out_valid_o,
`ifdef APBDMA_UPSIZER_BEAT_COUNT_EN
  output logic [CntWidth:0]       out_beats_o,
`endif
  input  logic                    out_ready_i
);

  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic [OutDataWidth-1:0] acc_data_q, acc_data_d;
  logic [OutStrbWidth-1:0] acc_strb_q, acc_strb_d;
  logic [OutDataWidth-1:0] out_data_q, out_data_d;
  logic [OutStrbWidth-1:0] out_strb_q, out_strb_d;
  logic                    out_last_q, out_last_d;
  logic                    out_valid_q, out_valid_d;
`ifdef APBDMA_UPSIZER_BEAT_COUNT_EN
  logic [CntWidth:0]       out_beats_q, out_beats_d;
`endif

  logic [OutDataWidth-1:0] merged_data;
  logic [OutStrbWidth-1:0] merged_strb;
  logic                    accept;
  logic                    complete;

  // Output slot is free, or is being drained this cycle.
  assign in_ready_o = ~out_valid_q | out_ready_i;
  assign accept     = in_valid_i & in_ready_o;
  assign complete   = in_last_i | (cnt_q == CntWidth'(Ratio - 1));

  // Accumulator with the incoming beat dropped into lane cnt_q. Lanes above cnt_q stay zero
  // because the accumulator is cleared after every completed word.
  always_comb begin
    merged_data = acc_data_q;
    merged_strb = acc_strb_q;
    for (int unsigned k = 0; k < Ratio; k++) begin
      if (cnt_q == CntWidth'(k)) begin
        merged_data[k*InDataWidth +: InDataWidth] = in_data_i;
        merged_strb[k*InStrbWidth +: InStrbWidth] = in_strb_i;
      end
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    acc_data_d  = acc_data_q;
    acc_strb_d  = acc_strb_q;
    out_data_d  = out_data_q;
    out_strb_d  = out_strb_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
`ifdef APBDMA_UPSIZER_BEAT_COUNT_EN
    out_beats_d = out_beats_q;
`endif

    if (accept) begin
      if (complete) begin
        cnt_d      = '0;
        acc_data_d = '0;
        acc_strb_d = '0;
      end else begin
        cnt_d      = cnt_q + CntWidth'(1);
        acc_data_d = merged_data;
        acc_strb_d = merged_strb;
      end
    end

    // A completing beat reloads the output register even while it is being drained.
    if (accept && complete) begin
      out_valid_d = 1'b1;
      out_data_d  = merged_data;
      out_strb_d  = merged_strb;
      out_last_d  = in_last_i;
`ifdef APBDMA_UPSIZER_BEAT_COUNT_EN
      out_beats_d = {1'b0, cnt_q} + (CntWidth + 1)'(1);
`endif
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      acc_data_q  <= '0;
      acc_strb_q  <= '0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef APBDMA_UPSIZER_BEAT_COUNT_EN
      out_beats_q <= '0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      acc_data_q  <= acc_data_d;
      acc_strb_q  <= acc_strb_d;
      out_data_q  <= out_data_d;
      out_strb_q  <= out_strb_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
`ifdef APBDMA_UPSIZER_BEAT_COUNT_EN
      out_beats_q <= out_beats_d;
`endif
    end
  end

  assign out_data_o  = out_data_q;
  assign out_strb_o  = out_strb_q;
  assign out_last_o  = out_last_q;
  assign out_valid_o = out_valid_q;
`ifdef APBDMA_UPSIZER_BEAT_COUNT_EN
  assign out_beats_o = out_beats_q;
`endif

endmodule

// File: tb/tb_apbdma_upsizer_flush.sv
// Testbench for apbdma_upsizer_flush (32 -> 128 bits, Ratio 4).
module tb_apbdma_upsizer_flush;

  localparam int unsigned InW = 32;
  localparam int unsigned OutW = 128;
  localparam int unsigned R = OutW / InW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     in_data = '0;
  logic [3:0]      in_strb = '0;
  logic            in_last = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [127:0]    out_data;
  logic [15:0]     out_strb;
  logic            out_last;
  logic            out_valid;
  logic            out_ready = 1'b1;
`ifdef APBDMA_UPSIZER_BEAT_COUNT_EN
  logic [2:0]      out_beats;
`endif

  apbdma_upsizer_flush #(
    .InDataWidth (InW),
    .OutDataWidth(OutW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_data_i  (in_data),
    .in_strb_i  (in_strb),
    .in_last_i  (in_last),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .out_data_o (out_data),
    .out_strb_o (out_strb),
    .out_last_o (out_last),
    .out_valid_o(out_valid),
`ifdef APBDMA_UPSIZER_BEAT_COUNT_EN
    .out_beats_o(out_beats),
`endif
    .out_ready_i(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  // Directed vectors: inputs for one cycle, expected outputs after the clock edge.
  typedef struct {
    logic         v;
    logic [31:0]  d;
    logic [3:0]   s;
    logic         l;
    logic         e_valid;
    logic [127:0] e_data;
    logic [15:0]  e_strb;
    logic         e_last;
    logic [2:0]   e_beats;
  } vec_t;

  // Reference model: narrow beats of the current word, and expected wide beats in order.
  typedef struct {
    logic [127:0] data;
    logic [15:0]  strb;
    logic         last;
    logic [2:0]   beats;
  } wide_t;

  logic [31:0] pend_d[$];
  logic [3:0]  pend_s[$];
  wide_t       exp_q[$];
  logic        rdy_seen;

  task automatic model_accept(input logic [31:0] d, input logic [3:0] s, input logic l);
    wide_t w;
    pend_d.push_back(d);
    pend_s.push_back(s);
    if (pend_d.size() == R || l) begin
      w.data = '0;
      w.strb = '0;
      for (int i = 0; i < pend_d.size(); i++) begin
        w.data = w.data | ({96'b0, pend_d[i]} << (32 * i));
        w.strb = w.strb | ({12'b0, pend_s[i]} << (4 * i));
      end
      w.last  = l;
      w.beats = 3'(pend_d.size());
      exp_q.push_back(w);
      pend_d.delete();
      pend_s.delete();
    end
  endtask

  // One clock cycle: drive, observe both handshakes just before the edge, then let it pass.
  task automatic cycle(input logic v, input logic [31:0] d, input logic [3:0] s, input logic l,
                       input logic ordy, output logic acc);
    wide_t w;
    @(negedge clk);
    in_valid = v; in_data = d; in_strb = s; in_last = l; out_ready = ordy;
    #1;
    rdy_seen = in_ready;
    acc = v & in_ready;
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wide_beat", 128'(out_valid), 128'(0));
      end else begin
        w = exp_q.pop_front();
        chk("wide_data", out_data, w.data);
        chk("wide_strb", 128'(out_strb), 128'(w.strb));
        chk("wide_last", 128'(out_last), 128'(w.last));
`ifdef APBDMA_UPSIZER_BEAT_COUNT_EN
        chk("wide_beats", 128'(out_beats), 128'(w.beats));
`endif
      end
    end
    if (acc) model_accept(d, s, l);
    @(posedge clk);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l,
                           input logic ordy);
    logic acc;
    int   n;
    n = 0;
    do begin
      cycle(1'b1, d, s, l, ordy, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 128'(acc), 128'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pend_d.delete();
    pend_s.delete();
    exp_q.delete();
  endtask

  vec_t vt[9];
  logic acc;
  logic [127:0] snap_d;
  logic [15:0]  snap_s;

  initial begin
    vt[0] = '{1, 32'h11111111, 4'hF, 0, 0, '0, '0, 0, 0};
    vt[1] = '{1, 32'h22222222, 4'hF, 0, 0, '0, '0, 0, 0};
    vt[2] = '{1, 32'h33333333, 4'hF, 0, 0, '0, '0, 0, 0};
    vt[3] = '{1, 32'h44444444, 4'hF, 1, 1,
              128'h44444444_33333333_22222222_11111111, 16'hFFFF, 1, 4};
    vt[4] = '{1, 32'hAAAA0001, 4'hF, 0, 0, '0, '0, 0, 0};
    vt[5] = '{1, 32'hBBBB0002, 4'hF, 1, 1,
              128'h00000000_00000000_BBBB0002_AAAA0001, 16'h00FF, 1, 2};
    vt[6] = '{1, 32'h12345678, 4'h0, 0, 0, '0, '0, 0, 0};
    vt[7] = '{1, 32'h9ABCDEF0, 4'h3, 1, 1,
              128'h00000000_00000000_9ABCDEF0_12345678, 16'h0030, 1, 2};
    vt[8] = '{0, 32'h0, 4'h0, 0, 0, '0, '0, 0, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_valid", 128'(out_valid), 128'(0));
    chk("reset_data", out_data, 128'(0));
    chk("reset_strb", 128'(out_strb), 128'(0));
    chk("reset_last", 128'(out_last), 128'(0));
`ifdef APBDMA_UPSIZER_BEAT_COUNT_EN
    chk("reset_beats", 128'(out_beats), 128'(0));
`endif

    // Directed table: full word, partial flush, sparse strobes.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = vt[i].v; in_data = vt[i].d; in_strb = vt[i].s; in_last = vt[i].l;
      out_ready = 1'b1;
      #1;
      chk($sformatf("vec%0d_ready", i), 128'(in_ready), 128'(1));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), 128'(out_valid), 128'(vt[i].e_valid));
      if (vt[i].e_valid) begin
        chk($sformatf("vec%0d_data", i), out_data, vt[i].e_data);
        chk($sformatf("vec%0d_strb", i), 128'(out_strb), 128'(vt[i].e_strb));
        chk($sformatf("vec%0d_last", i), 128'(out_last), 128'(vt[i].e_last));
`ifdef APBDMA_UPSIZER_BEAT_COUNT_EN
        chk($sformatf("vec%0d_beats", i), 128'(out_beats), 128'(vt[i].e_beats));
`endif
      end
    end

    // Backpressure: complete a word, stall five cycles with a beat offered, then release.
    for (int i = 0; i < 4; i++) send_beat(32'hC0DE0000 + 32'(i), 4'hF, i == 3, 1'b1);
    #1;
    snap_d = out_data;
    snap_s = out_strb;
    chk("bp_valid_start", 128'(out_valid), 128'(1));
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'h5555AAAA, 4'hF, 1'b1, 1'b0, acc);
      chk("bp_ready_low", 128'(rdy_seen), 128'(0));
      #1;
      chk("bp_valid_held", 128'(out_valid), 128'(1));
      chk("bp_data_held", out_data, snap_d);
      chk("bp_strb_held", 128'(out_strb), 128'(snap_s));
    end
    send_beat(32'h5555AAAA, 4'hF, 1'b1, 1'b1);

    // Streaming: 16 back-to-back beats, never stalled.
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 32'(i), 4'hF, i == 16, 1'b1, acc);
      chk("stream_ready", 128'(acc), 128'(1));
    end

    // Reset mid-burst discards the partial word; next burst restarts at lane 0.
    for (int i = 0; i < 3; i++) send_beat(32'hDEAD0000 + 32'(i), 4'hF, 1'b0, 1'b1);
    do_reset();
    chk("midreset_valid", 128'(out_valid), 128'(0));
    send_beat(32'hCAFEF00D, 4'h5, 1'b1, 1'b1);
    #1;
    chk("postreset_data", out_data, 128'h0000_0000_0000_0000_0000_0000_CAFE_F00D);
    chk("postreset_strb", 128'(out_strb), 128'h5);

`ifdef APBDMA_UPSIZER_BEAT_COUNT_EN
    for (int i = 0; i < 3; i++) send_beat(32'hB0000000 + 32'(i), 4'hF, i == 2, 1'b1);
    #1;
    chk("beats_partial3", 128'(out_beats), 128'(3));
    for (int i = 0; i < 4; i++) send_beat(32'hB1000000 + 32'(i), 4'hF, 1'b0, 1'b1);
    #1;
    chk("beats_full", 128'(out_beats), 128'(4));
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom, 4'($urandom),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) < 7), acc);
    end
    // Close any open burst, then drain.
    send_beat(32'hF1F1F1F1, 4'hF, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk("drain_empty", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/apbdma_upsizer_flush.md
Name: apbdma_upsizer_flush

Overview:
- Parametrised successor to the DMA data-path upsizer.
- Packs Ratio = OutDataWidth/InDataWidth narrow beats into one wide beat, with byte strobes kept per lane.
- Flushes a partially filled wide word when the burst ends (in_last_i).
- Runs at full throughput through a separate output register. Sits between the APB read side and the wide write side of the DMA.

Parameters:
- InDataWidth, 32, narrow data width in bits; multiple of 8.
- OutDataWidth, 128, wide data width in bits. OutDataWidth/InDataWidth must be a power of two, >= 2.
- CntWidth, derived, max(1, clog2(OutDataWidth/InDataWidth)). Not overridable.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- in_data_i  in  InDataWidth  narrow data.
- in_strb_i  in  InDataWidth/8  narrow byte strobes.
- in_last_i  in  1  final narrow beat of the burst.
- in_valid_i  in  1  narrow beat valid.
- in_ready_o  out  1  narrow beat accepted when in_valid_i and in_ready_o are both high.
- out_data_o  out  OutDataWidth  packed wide data.
- out_strb_o  out  OutDataWidth/8  packed wide strobes.
- out_last_o  out  1  wide beat ends the burst.
- out_valid_o  out  1  wide beat valid.
- out_ready_i  in  1  wide beat consumed when out_valid_o and out_ready_i are both high.

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is synchronous and active-high on rst_i; all registers are updated only on the rising edge of clk_i.
  - Reset clears lane counter cnt_q, accumulator data/strb, and the output register.
  - Reset values: out_valid_o=0, out_data_o=0, out_strb_o=0, out_last_o=0.
  - Reset mid-burst discards all partial and pending data; no flush is emitted.
- Lanes:
  - Lane k occupies bits [k*InDataWidth +: InDataWidth] and strobes [k*InDataWidth/8 +: InDataWidth/8].
  - Lane 0 is filled first (little-endian packing).
- Ready:
  - in_ready_o = !out_valid_o | out_ready_i, combinational.
  - in_ready_o does not depend on in_valid_i.
- Accepted narrow beat:
  - Data and strobes are written into lane cnt_q.
  - The beat is "completing" if cnt_q == Ratio-1 or in_last_i=1.
  - Non-completing beat: cnt_q increments; the accumulator holds the partial word.
  - Completing beat: next cycle, the output register takes the accumulator with the current lane merged in.
    - Lanes above cnt_q (unwritten on flush) have data=0 and strb=0.
    - out_last_o = in_last_i.
    - out_valid_o = 1.
    - cnt_q and the accumulator clear to 0.
- Latency and throughput:
  - Wide beat is valid 1 cycle after the completing narrow beat.
  - With out_ready_i held high, continuous input gives 1 wide beat every Ratio cycles with no input bubbles.
- Output register:
  - Output register is a plain state: Empty when out_valid_o=0, Full when out_valid_o=1.
  - Empty -> Full on a completing beat.
  - Full -> Empty on out_ready_i with no completing beat.
  - Full -> Full (reloaded) when out_ready_i and a completing beat coincide.
  - While Full and out_ready_i=0, out_data_o, out_strb_o and out_last_o are held stable and in_ready_o=0.
- Boundary conditions:
  - in_last_i on lane Ratio-1 produces a full word with out_last_o=1.
  - in_last_i on lane 0 produces a word with only lane 0 populated.
  - cnt_q wraps Ratio-1 -> 0; never exceeds Ratio-1.
  - in_strb_i=0 beats still occupy a lane; they are counted, not skipped.
- Not supported: no downsizing, no unaligned start lane.

Optional Feature:
- Macro: APBDMA_UPSIZER_BEAT_COUNT_EN.
- When defined:
  - Adds output port out_beats_o, width CntWidth+1.
  - out_beats_o gives the number of narrow beats packed into the current wide beat (1..Ratio).
  - Registered alongside out_data_o; reset value 0; held stable while stalled.
- When undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Full word:
  - Stimulus: In=32, Out=128, out_ready_i=1; beats 0x11111111, 0x22222222, 0x33333333, 0x44444444, strb 0xF, last on beat 4.
  - Required response: 1 cycle later out_data_o=0x44444444_33333333_22222222_11111111, out_strb_o=0xFFFF, out_last_o=1.
- Partial flush:
  - Stimulus: 2 beats 0xAAAA0001, 0xBBBB0002, last on beat 2.
  - Required response: out_data_o=0x00000000_00000000_BBBB0002_AAAA0001, out_strb_o=0x00FF, out_last_o=1; next burst begins at lane 0.
- Backpressure:
  - Stimulus: complete one word, hold out_ready_i=0 for 5 cycles, drive in_valid_i=1 throughout.
  - Required response: in_ready_o=0, outputs stable for those 5 cycles; no beat lost after release.
- Streaming:
  - Stimulus: 16 back-to-back beats (values 1..16), out_ready_i=1.
  - Required response: 4 wide beats, in_ready_o constantly 1, out_last_o=1 only on the 4th.
- Sparse strobes and reset:
  - Stimulus: beat strb 0x0 then 0x3 with last.
  - Required response: out_strb_o=0x0030.
  - Stimulus: assert rst_i after 3 beats of the next burst.
  - Required response: out_valid_o=0, and the following burst's first beat lands in lane 0.
- Beat count (APBDMA_UPSIZER_BEAT_COUNT_EN defined):
  - Stimulus: partial flush of 3 beats.
  - Required response: out_beats_o=3.
  - Stimulus: a full word.
  - Required response: out_beats_o=4.
